qspi_mem_ctrl: RTL and testbench
================================

Name: qspi_mem_ctrl

Overview:
Word-level QSPI master serving the SoC bus. It drives the two external memory chips: PSRAM on ce0/sclk_ram and NOR flash on ce1/sclk_nor. It sits directly upstream of the chip-top pin mux and produces the ce0, ce1, sclk_ram, sclk_nor, sio*_o and sio_oe signals that the mux routes to the PMOD. Each request performs one 32-bit read, or one contiguous byte/halfword/word write to PSRAM.

Parameters:
DUMMY_RAM, 6, dummy sclk periods for a PSRAM quad read (0xEB)
DUMMY_NOR, 6, dummy sclk periods for a NOR quad read (0xEB; includes 2 mode periods)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  bus request; sampled only in IDLE
ready  out  1  one-cycle completion pulse
sel  in  1  0 = PSRAM (ce0), 1 = NOR (ce1)
addr  in  24  byte address; bits [1:0] ignored
wdata  in  32  write data, little-endian byte lanes
wstrb  in  4  0000 = read; otherwise byte enables (contiguous)
rdata  out  32  read data; valid while ready=1
ce0  out  1  PSRAM chip select, active low
ce1  out  1  NOR chip select, active low
sclk_ram  out  1  PSRAM serial clock
sclk_nor  out  1  NOR serial clock
sio_o  out  4  serial data out; bit 0 = sio0/MOSI
sio_i  in  4  serial data in
sio_oe  out  4  per-line output enable, active high

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - ce0 = ce1 = 1; sclk_ram = sclk_nor = 0.
  - sio_o = 0; sio_oe = 0; ready = 0; rdata = 0.
  - State = IDLE.
- Clocking:
  - sclk = clk/2. Each sclk period is 2 clk cycles: LOW phase, then HIGH phase.
  - Outputs change only at the start of the LOW phase.
  - sio_i is sampled on the clk edge that ends the HIGH phase.
  - Only the selected device's sclk toggles. The other stays 0.
- Acceptance:
  - In IDLE with valid=1, the controller latches sel, addr, wdata and wstrb on that edge (E0).
  - Later changes on these inputs are ignored until ready.
  - valid outside IDLE is ignored.
- States: IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> DONE -> GAP -> IDLE.
- CMD:
  - 8 periods, single-bit, MSB first on sio0; sio_oe = 0001.
  - Command 0xEB for read, 0x38 for write.
  - The selected ce goes low in the cycle after E0.
- ADDR:
  - 6 periods, quad, MSB nibble first; sio_oe = 1111.
  - Read address = {addr[23:2], 2'b00}.
  - Write address = {addr[23:2], lo}, where lo = index of the lowest set wstrb bit.
- DUMMY (reads only):
  - DUMMY_RAM or DUMMY_NOR periods; sio_oe = 0000; sio_o = 0.
- DATA, read:
  - 8 periods; sio_oe = 0000.
  - Byte order is byte0 first; within each byte, high nibble first.
  - Nibbles are assembled into rdata.
- DATA, write:
  - 2*(hi-lo+1) periods, where hi = index of the highest set wstrb bit.
  - sio_oe = 1111.
  - Sends bytes lo..hi of wdata in the same order as reads (low byte first, high nibble first).
  - Bytes between lo and hi are written even if their strobe is 0. The bus guarantees contiguous strobes.
- DONE:
  - ce returns high; sclk = 0; sio_oe = 0.
  - ready = 1 for exactly one cycle.
  - ready occurs in cycle 2K+1 after E0, where K = total sclk periods.
  - Default K: read = 28; full write = 22; single-byte write = 16.
- GAP:
  - 2 clk cycles with both ce high.
  - Guarantees ce-high time ≥ 1 sclk period before the next CMD.
- Write to NOR (sel=1, wstrb≠0):
  - No pin activity; ready pulses in cycle 1 after E0; rdata unchanged.
- rdata:
  - Holds its last value after ready; updated only by completed reads.
- Back-to-back requests:
  - valid held high: the next request is accepted in the first IDLE cycle after GAP.
- ce0 and ce1 are never low simultaneously.

Test Plan:
- Reset: assert rst_n=0 mid-DATA of a PSRAM read -> ce0=1, sclk_ram=0, sio_oe=0 in the same cycle; next valid starts a clean CMD.
- PSRAM read: sel=0, addr=0x001234, memory model returns bytes 0x11,0x22,0x33,0x44 -> sio0 sends 0xEB, address nibbles 0,0,1,2,3,4, 6 dummy periods, ready in cycle 57, rdata=0x44332211.
- NOR read: sel=1, addr=0x000100 -> only ce1/sclk_nor active; sclk_ram stays 0; ready in cycle 57; rdata matches the model.
- Full write: sel=0, addr=0x000010, wdata=0xDEADBEEF, wstrb=1111 -> command 0x38, address 0x000010, nibbles E,F,B,E,A,D,D,E with sio_oe=1111, ready in cycle 45.
- Byte write: wstrb=0100, addr=0x000020, wdata=0x00AB0000 -> address 0x000022, nibbles A,B, ready in cycle 33.
- NOR write plus back-to-back: sel=1, wstrb=1111 -> ready in cycle 1, ce1 never low. Then valid held high for two PSRAM reads -> ce0 high for ≥2 cycles between them.

Source files
------------

// File: rtl/qspi_mem_ctrl.sv
// qspi_mem_ctrl: word-level QSPI master for a PSRAM (ce0/sclk_ram) and a
// NOR flash (ce1/sclk_nor). One request = one 32-bit quad read (0xEB) or one
// contiguous byte/halfword/word quad write (0x38, PSRAM only).
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   valid/ready        request (sampled in IDLE) / one-cycle completion pulse
//   sel                0 = PSRAM, 1 = NOR
//   addr, wdata, wstrb byte address, write data, byte enables (0000 = read)
//   rdata              read data, updated only by completed reads
//   ce0, ce1           active-low chip selects
//   sclk_ram, sclk_nor serial clocks (clk/2, only the selected one toggles)
//   sio_o, sio_i       serial data out/in, bit 0 = sio0
//   sio_oe             per-line output enable
//
// state | meaning
// IDLE  | waiting for valid
// CMD   | 8 single-bit command periods on sio0
// ADDR  | 6 quad address periods
// DUMMY | read turnaround periods, lines released
// DATA  | quad data periods (read or write)
// DONE  | ce high, ready pulse
// GAP   | 2 cycles of ce high before the next request

module qspi_mem_ctrl #(
  parameter int DUMMY_RAM = 6,
  parameter int DUMMY_NOR = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  output logic        ready,
  input  logic        sel,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        ce0,
  output logic        ce1,
  output logic        sclk_ram,
  output logic        sclk_nor,
  output logic [3:0]  sio_o,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_oe
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;      // periods left in the current state, minus one
  logic        phase_q, phase_d;  // 0 = sclk LOW phase, 1 = HIGH phase
  logic [31:0] sh_q, sh_d;
  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [23:0] adr_q, adr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [2:0]  wlen_q, wlen_d;    // write data periods minus one
  logic        ready_d;
  logic [31:0] rdata_d;
  logic        busy_d;
  logic [3:0]  sio_o_d, sio_oe_d;
  logic [1:0]  lo, hi;
  logic [31:0] wswap, sh_in, rswap;
  logic [5:0]  dummy_n;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], sh_q[31]};
  assign dummy_n = sel_q ? 6'(DUMMY_NOR) : 6'(DUMMY_RAM);

  always_comb begin
    lo = 2'd0;
    hi = 2'd0;
    for (int i = 3; i >= 0; i--) if (wstrb[i]) lo = 2'(i);
    for (int i = 0; i < 4; i++) if (wstrb[i]) hi = 2'(i);
  end

  // Bytes go out low byte first, so byte-swap and left-align byte lo.
  assign wswap = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} << {lo, 3'b000};
  assign sh_in = {sh_q[27:0], sio_i};
  assign rswap = {sh_in[7:0], sh_in[15:8], sh_in[23:16], sh_in[31:24]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    wbuf_d  = wbuf_q;
    wlen_d  = wlen_q;
    ready_d = 1'b0;
    rdata_d = rdata;
    case (state_q)
      IDLE: if (valid) begin
        sel_d   = sel;
        wr_d    = |wstrb;
        adr_d   = {addr[23:2], ((|wstrb) ? lo : 2'b00)};
        wbuf_d  = wswap;
        wlen_d  = {hi - lo, 1'b1};
        phase_d = 1'b0;
        if (sel && (|wstrb)) begin
          state_d = DONE;  // NOR is read-only: complete without pin activity
          ready_d = 1'b1;
        end else begin
          state_d = CMD;
          cnt_d   = 6'd7;
          sh_d    = {((|wstrb) ? 8'h38 : 8'hEB), 24'h0};
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (state_q == DATA && !wr_q) sh_d = sh_in;
          if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
            if (state_q == CMD) sh_d = {sh_q[30:0], 1'b0};
            else if (state_q == ADDR || (state_q == DATA && wr_q)) sh_d = {sh_q[27:0], 4'h0};
          end else begin
            case (state_q)
              CMD: begin
                state_d = ADDR;
                cnt_d   = 6'd5;
                sh_d    = {adr_q, 8'h0};
              end
              ADDR: begin
                if (wr_q) begin
                  state_d = DATA;
                  cnt_d   = {3'b000, wlen_q};
                  sh_d    = wbuf_q;
                end else if (dummy_n != 6'd0) begin
                  state_d = DUMMY;
                  cnt_d   = dummy_n - 6'd1;
                  sh_d    = 32'h0;
                end else begin
                  state_d = DATA;
                  cnt_d   = 6'd7;
                  sh_d    = 32'h0;
                end
              end
              DUMMY: begin
                state_d = DATA;
                cnt_d   = 6'd7;
              end
              default: begin
                state_d = DONE;
                ready_d = 1'b1;
                if (!wr_q) rdata_d = rswap;
              end
            endcase
          end
        end
      end
      DONE: begin
        state_d = GAP;
        cnt_d   = 6'd1;
      end
      GAP: begin
        if (cnt_q == 6'd0) state_d = IDLE;
        else cnt_d = cnt_q - 6'd1;
      end
      default: state_d = IDLE;
    endcase

    // Pin values are registered from the next state so they only move at
    // the start of a LOW phase.
    busy_d   = (state_d == CMD) || (state_d == ADDR) || (state_d == DUMMY) || (state_d == DATA);
    sio_o_d  = 4'h0;
    sio_oe_d = 4'h0;
    case (state_d)
      CMD: begin
        sio_o_d  = {3'b000, sh_d[31]};
        sio_oe_d = 4'b0001;
      end
      ADDR: begin
        sio_o_d  = sh_d[31:28];
        sio_oe_d = 4'b1111;
      end
      DATA: if (wr_d) begin
        sio_o_d  = sh_d[31:28];
        sio_oe_d = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      phase_q  <= 1'b0;
      sh_q     <= 32'h0;
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      adr_q    <= 24'h0;
      wbuf_q   <= 32'h0;
      wlen_q   <= 3'd0;
      ready    <= 1'b0;
      rdata    <= 32'h0;
      ce0      <= 1'b1;
      ce1      <= 1'b1;
      sclk_ram <= 1'b0;
      sclk_nor <= 1'b0;
      sio_o    <= 4'h0;
      sio_oe   <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      sh_q     <= sh_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      adr_q    <= adr_d;
      wbuf_q   <= wbuf_d;
      wlen_q   <= wlen_d;
      ready    <= ready_d;
      rdata    <= rdata_d;
      ce0      <= ~(busy_d & ~sel_d);
      ce1      <= ~(busy_d & sel_d);
      sclk_ram <= busy_d & phase_d & ~sel_d;
      sclk_nor <= busy_d & phase_d & sel_d;
      sio_o    <= sio_o_d;
      sio_oe   <= sio_oe_d;
    end
  end

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Testbench for qspi_mem_ctrl: directed requests; expected responses and
// expected pin frames are queued at issue time and checked by separate
// monitor processes. A small memory model answers quad reads on sio_i.

module tb_qspi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid, sel;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        ce0, ce1, sclk_ram, sclk_nor;
  logic [3:0]  sio_o, sio_i, sio_oe;

  qspi_mem_ctrl #(.DUMMY_RAM(6), .DUMMY_NOR(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready), .sel(sel),
    .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata),
    .ce0(ce0), .ce1(ce1), .sclk_ram(sclk_ram), .sclk_nor(sclk_nor),
    .sio_o(sio_o), .sio_i(sio_i), .sio_oe(sio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          e0;
    int          lat;
    logic [31:0] rd;
  } rsp_t;

  typedef struct {
    logic        dev;
    logic [7:0]  cmd;
    logic [23:0] adr;
    int          np;
    logic [31:0] wnib;
  } frm_t;

  rsp_t exp_q[$];
  frm_t fexp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_rsp = 0;
  int   viol = 0;
  logic ignore_frame = 1'b0;
  logic [7:0] ram [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic dev, input logic [23:0] a);
    return dev ? (a[7:0] ^ 8'h5A) : ram[a[7:0]];
  endfunction

  // Response monitor
  initial begin
    rsp_t r;
    logic prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (ready) begin
          if (prev_ready) viol++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ready_unexpected actual=1 required=0");
          end else begin
            r = exp_q.pop_front();
            chk("ready_cycle", 32'(cyc - r.e0 + 1), 32'(r.lat));
            chk("rdata", rdata, r.rd);
          end
          n_rsp++;
        end
        prev_ready = ready;
      end
    end
  end

  // Pin monitor and memory model
  initial begin
    logic        act_prev = 1'b0, sck_prev = 1'b0, o_dev = 1'b0, seen = 1'b0, sck, active;
    logic [7:0]  o_cmd = 8'h0, b;
    logic [23:0] o_adr = 24'h0;
    logic [31:0] o_w = 32'h0;
    logic [3:0]  f_oe [0:63];
    logic [3:0]  f_so [0:63];
    int          p = 0, hi_run = 0, bad, np;
    logic [3:0]  eoe;
    frm_t        fe;
    sio_i = 4'h0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (!ce0 && !ce1) viol++;
        if (ce0 && sclk_ram) viol++;
        if (ce1 && sclk_nor) viol++;
        active = !ce0 || !ce1;
        if (active && !act_prev) begin
          if (seen && hi_run < 2) viol++;
          seen = 1'b1;
          p = 0; o_dev = !ce1; o_cmd = 8'h0; o_adr = 24'h0; o_w = 32'h0; sck_prev = 1'b0;
        end
        sck = o_dev ? sclk_nor : sclk_ram;
        if (active && sck && !sck_prev) begin
          if (p < 64) begin
            f_oe[p] = sio_oe;
            f_so[p] = sio_o;
          end
          if (p < 8) o_cmd = {o_cmd[6:0], sio_o[0]};
          else if (p < 14) o_adr = {o_adr[19:0], sio_o};
          else if (o_cmd == 8'h38) begin
            if (p < 22) o_w = o_w | (32'(sio_o) << (28 - 4 * (p - 14)));
          end else if (p >= 20 && p < 28) begin
            b = mem_rd(o_dev, o_adr + 24'((p - 20) / 2));
            sio_i = ((p - 20) % 2 == 0) ? b[7:4] : b[3:0];
          end
          p++;
        end
        if (active) sck_prev = sck;
        if (!active && act_prev) begin
          if (ignore_frame) ignore_frame = 1'b0;
          else if (fexp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_unexpected actual=%0d periods required=none", p);
          end else begin
            fe = fexp_q.pop_front();
            chk("frame_dev", 32'(o_dev), 32'(fe.dev));
            chk("frame_cmd", 32'(o_cmd), 32'(fe.cmd));
            chk("frame_addr", 32'(o_adr), 32'(fe.adr));
            chk("frame_periods", 32'(p), 32'(fe.np));
            if (fe.cmd == 8'h38) chk("frame_wdata", o_w, fe.wnib);
            bad = 0;
            np = (p < 64) ? p : 64;
            for (int k = 0; k < np; k++) begin
              eoe = (k < 8) ? 4'b0001 : ((k < 14 || fe.cmd == 8'h38) ? 4'b1111 : 4'b0000);
              if (f_oe[k] !== eoe) bad++;
              if (eoe == 4'b0000 && f_so[k] !== 4'h0) bad++;
            end
            chk("frame_oe", 32'(bad), 32'd0);
          end
        end
        hi_run = active ? 0 : hi_run + 1;
        act_prev = active;
      end
    end
  end

  int tgt = 0;

  task automatic wait_rsp(input int target);
    int n = 0;
    while (n_rsp < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n_rsp < target) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=%0d responses required=%0d", n_rsp, target);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic push_exp(input int e0, input logic s, input logic [3:0] ws,
                          input logic [23:0] fa, input int np, input logic [31:0] fw,
                          input int lat, input logic [31:0] erd);
    rsp_t r;
    frm_t f;
    r.e0 = e0; r.lat = lat; r.rd = erd;
    exp_q.push_back(r);
    if (!(s && ws != 4'h0)) begin
      f.dev = s; f.cmd = (ws == 4'h0) ? 8'hEB : 8'h38; f.adr = fa; f.np = np; f.wnib = fw;
      fexp_q.push_back(f);
    end
  endtask

  task automatic issue(input logic s, input logic [23:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [23:0] fa, input int np,
                       input logic [31:0] fw, input int lat, input logic [31:0] erd);
    @(negedge clk);
    valid = 1'b1; sel = s; addr = a; wdata = wd; wstrb = ws;
    push_exp(cyc + 1, s, ws, fa, np, fw, lat, erd);
    @(negedge clk);
    valid = 1'b0; sel = ~s; addr = ~a; wdata = ~wd; wstrb = ~ws;
    tgt++;
    wait_rsp(tgt);
  endtask

  initial begin
    int e0;
    valid = 1'b0; sel = 1'b0; addr = 24'h0; wdata = 32'h0; wstrb = 4'h0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[8'h34] = 8'h11; ram[8'h35] = 8'h22; ram[8'h36] = 8'h33; ram[8'h37] = 8'h44;
    ram[8'h40] = 8'hA1; ram[8'h41] = 8'hB2; ram[8'h42] = 8'hC3; ram[8'h43] = 8'hD4;

    repeat (3) @(negedge clk);
    chk("rst_ce0", 32'(ce0), 32'd1);
    chk("rst_ce1", 32'(ce1), 32'd1);
    chk("rst_sclk", 32'({sclk_ram, sclk_nor}), 32'd0);
    chk("rst_sio_o", 32'(sio_o), 32'd0);
    chk("rst_sio_oe", 32'(sio_oe), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // PSRAM read, NOR read
    issue(1'b0, 24'h001234, 32'h0, 4'b0000, 24'h001234, 28, 32'h0, 57, 32'h44332211);
    issue(1'b1, 24'h000100, 32'h0, 4'b0000, 24'h000100, 28, 32'h0, 57, 32'h59585B5A);
    // Writes: full word, single byte, halfword; rdata keeps last read
    issue(1'b0, 24'h000010, 32'hDEADBEEF, 4'b1111, 24'h000010, 22, 32'hEFBEADDE, 45, 32'h59585B5A);
    issue(1'b0, 24'h000020, 32'h00AB0000, 4'b0100, 24'h000022, 16, 32'hAB000000, 33, 32'h59585B5A);
    issue(1'b0, 24'h000030, 32'h12345678, 4'b0110, 24'h000031, 18, 32'h56340000, 37, 32'h59585B5A);
    // NOR write: no frame, ready in cycle 1
    issue(1'b1, 24'h000200, 32'hCAFEF00D, 4'b1111, 24'h0, 0, 32'h0, 1, 32'h59585B5A);

    // Back-to-back reads with valid held high; second address has low bits set
    @(negedge clk);
    valid = 1'b1; sel = 1'b0; addr = 24'h001234; wstrb = 4'b0000; wdata = 32'h0;
    e0 = cyc + 1;
    push_exp(e0, 1'b0, 4'b0000, 24'h001234, 28, 32'h0, 57, 32'h44332211);
    @(negedge clk);
    addr = 24'h000043;
    push_exp(e0 + 60, 1'b0, 4'b0000, 24'h000040, 28, 32'h0, 57, 32'hD4C3B2A1);
    while (cyc < e0 + 60) @(negedge clk);
    valid = 1'b0;
    tgt += 2;
    wait_rsp(tgt);

    // Reset in the middle of a PSRAM read data phase
    @(negedge clk);
    ignore_frame = 1'b1;
    valid = 1'b1; sel = 1'b0; addr = 24'h001234; wstrb = 4'b0000;
    e0 = cyc + 1;
    @(negedge clk);
    valid = 1'b0;
    while (cyc < e0 + 44) @(negedge clk);
    chk("pre_rst_ce0_low", 32'(ce0), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ce0", 32'(ce0), 32'd1);
    chk("mid_rst_sclk_ram", 32'(sclk_ram), 32'd0);
    chk("mid_rst_sio_oe", 32'(sio_oe), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, 24'h001234, 32'h0, 4'b0000, 24'h001234, 28, 32'h0, 57, 32'h44332211);

    chk("pin_rules", 32'(viol), 32'd0);
    chk("rsp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_queue_empty", 32'(fexp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
